// File: rtl/ramp_checker_if.sv
// Sample stream and status bundle between a ramp source/bench
// and the ramp checker.
//
// master: drives enable, data_in, clear; observes checker status.
// slave : the checker; consumes the sample stream, drives locked,
//         error, expected and the three statistics counters.
interface ramp_checker_if #(
    parameter int WIDTH     = 7,
    parameter int CNT_WIDTH = 16
);
    logic                 enable;
    logic [WIDTH-1:0]     data_in;
    logic                 clear;
    logic                 locked;
    logic                 error;
    logic [WIDTH-1:0]     expected;
    logic [CNT_WIDTH-1:0] error_count;
    logic [CNT_WIDTH-1:0] sample_count;
    logic [CNT_WIDTH-1:0] wrap_count;

    modport master (
        output enable, data_in, clear,
        input  locked, error, expected,
        input  error_count, sample_count, wrap_count
    );

    modport slave (
        input  enable, data_in, clear,
        output locked, error, expected,
        output error_count, sample_count, wrap_count
    );
endinterface

// File: rtl/ramp_checker.sv
// Receive-side ramp monitor: locks onto a modulo-2^WIDTH incrementing
// stream, then flags/counts broken steps and counts wrap-arounds.
//
// Ports: clock (rising edge), reset (async, active-low),
//        bus (ramp_checker_if.slave: enable, data_in, clear in;
//        locked, error, expected, error/sample/wrap counts out).
module ramp_checker #(
    parameter int WIDTH      = 7,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic          clock,
    input  logic          reset,
    ramp_checker_if.slave bus
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(LOSS_COUNT + 1);

    localparam logic [WIDTH-1:0]     D_ONE     = 1;
    localparam logic [GW-1:0]        G_ONE     = 1;
    localparam logic [BW-1:0]        B_ONE     = 1;
    localparam logic [CNT_WIDTH-1:0] C_ONE     = 1;
    localparam logic [GW-1:0]        LOCK_G    = GW'(LOCK_COUNT);
    localparam logic [BW-1:0]        LOSS_LAST = BW'(LOSS_COUNT - 1);

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     expected, exp_n;
    logic [GW-1:0]        good_run, good_n;
    logic [BW-1:0]        bad_run, bad_n;
    logic                 error, err_n;
    logic [CNT_WIDTH-1:0] error_count, sample_count, wrap_count;
    logic                 inc_sample, inc_error, inc_wrap;

    logic             match;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] exp_inc;

    assign match     = (bus.data_in == expected);
    assign data_next = bus.data_in + D_ONE;
    assign exp_inc   = expected + D_ONE;

    // good_run counts samples in the current clean run, so lock is
    // declared on the match that completes LOCK_COUNT verified steps.
    always_comb begin
        state_n    = state;
        exp_n      = expected;
        good_n     = good_run;
        bad_n      = bad_run;
        err_n      = 1'b0;
        inc_sample = 1'b0;
        inc_error  = 1'b0;
        inc_wrap   = 1'b0;
        if (bus.enable) begin
            unique case (state)
                SEARCH: begin
                    exp_n   = data_next;
                    good_n  = G_ONE;
                    state_n = ACQUIRE;
                end
                ACQUIRE: begin
                    if (match) begin
                        exp_n = exp_inc;
                        if (good_run == LOCK_G) begin
                            state_n = LOCKED;
                            bad_n   = '0;
                        end else begin
                            good_n = good_run + G_ONE;
                        end
                    end else begin
                        exp_n  = data_next;
                        good_n = G_ONE;
                    end
                end
                LOCKED: begin
                    inc_sample = 1'b1;
                    exp_n      = exp_inc;
                    if (match) begin
                        bad_n    = '0;
                        inc_wrap = (bus.data_in == '0);
                    end else begin
                        err_n     = 1'b1;
                        inc_error = 1'b1;
                        if (bad_run == LOSS_LAST) begin
                            state_n = ACQUIRE;
                            exp_n   = data_next;
                            good_n  = G_ONE;
                            bad_n   = '0;
                        end else begin
                            bad_n = bad_run + B_ONE;
                        end
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= SEARCH;
            expected <= '0;
            good_run <= '0;
            bad_run  <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_n;
            expected <= exp_n;
            good_run <= good_n;
            bad_run  <= bad_n;
            error    <= err_n;
        end
    end

    // clear wins over a same-cycle increment; counters hold at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            error_count  <= '0;
            sample_count <= '0;
            wrap_count   <= '0;
        end else if (bus.clear) begin
            error_count  <= '0;
            sample_count <= '0;
            wrap_count   <= '0;
        end else begin
            if (inc_error && error_count != '1)
                error_count <= error_count + C_ONE;
            if (inc_sample && sample_count != '1)
                sample_count <= sample_count + C_ONE;
            if (inc_wrap && wrap_count != '1)
                wrap_count <= wrap_count + C_ONE;
        end
    end

    assign bus.locked       = (state == LOCKED);
    assign bus.error        = error;
    assign bus.expected     = expected;
    assign bus.error_count  = error_count;
    assign bus.sample_count = sample_count;
    assign bus.wrap_count   = wrap_count;
endmodule

// File: tb/tb_ramp_checker.sv
// Directed bench for ramp_checker: lock acquisition, single and burst
// errors, enable gaps, clear, and asynchronous reset mid-stream.
module tb_ramp_checker;
    logic clock;
    logic reset;
    int   errors;
    int   checks;

    ramp_checker_if #(.WIDTH(7), .CNT_WIDTH(16)) bus ();

    ramp_checker #(
        .WIDTH(7),
        .LOCK_COUNT(4),
        .LOSS_COUNT(3),
        .CNT_WIDTH(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs at the falling edge, then settle
    // just after the following rising edge.
    task automatic step(input logic en, input logic [6:0] d,
                        input logic clr);
        @(negedge clock);
        bus.enable  = en;
        bus.data_in = d;
        bus.clear   = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b0;
        bus.enable  = 1'b0;
        bus.data_in = '0;
        bus.clear   = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic feed(input int first, input int last);
        for (int i = first; i <= last; i++)
            step(1'b1, 7'(i % 128), 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.locked !== 1'b0 || bus.error !== 1'b0 ||
            bus.expected !== 7'd0) begin
            errors++;
            $display("FAIL reset_status got l=%b e=%b x=%0d want 0 0 0",
                     bus.locked, bus.error, bus.expected);
        end
        checks++;
        if (bus.error_count !== 16'd0 || bus.sample_count !== 16'd0 ||
            bus.wrap_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts got %0d %0d %0d want 0 0 0",
                     bus.error_count, bus.sample_count, bus.wrap_count);
        end
    endtask

    task automatic test_clean_ramp();
        do_reset();
        for (int i = 0; i <= 200; i++) begin
            step(1'b1, 7'(i % 128), 1'b0);
            checks++;
            if (bus.locked !== (i >= 4)) begin
                errors++;
                $display("FAIL clean_locked i=%0d got=%b want=%b",
                         i, bus.locked, (i >= 4));
            end
            checks++;
            if (bus.error !== 1'b0) begin
                errors++;
                $display("FAIL clean_error i=%0d got=%b want=0",
                         i, bus.error);
            end
            if (i == 0 || i == 127) begin
                checks++;
                if (bus.expected !== 7'((i + 1) % 128)) begin
                    errors++;
                    $display("FAIL clean_expected i=%0d got=%0d want=%0d",
                             i, bus.expected, (i + 1) % 128);
                end
            end
        end
        checks++;
        if (bus.wrap_count !== 16'd1) begin
            errors++;
            $display("FAIL clean_wraps got=%0d want=1", bus.wrap_count);
        end
        checks++;
        if (bus.sample_count !== 16'd196) begin
            errors++;
            $display("FAIL clean_samples got=%0d want=196",
                     bus.sample_count);
        end
        checks++;
        if (bus.error_count !== 16'd0) begin
            errors++;
            $display("FAIL clean_errcnt got=%0d want=0", bus.error_count);
        end
        checks++;
        if (bus.expected !== 7'd73) begin
            errors++;
            $display("FAIL clean_final_exp got=%0d want=73", bus.expected);
        end
    endtask

    task automatic test_single_error();
        int pulses;
        do_reset();
        feed(0, 39);
        step(1'b1, 7'h55, 1'b0);
        checks++;
        if (bus.error !== 1'b1 || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse got e=%b l=%b want 1 1",
                     bus.error, bus.locked);
        end
        checks++;
        if (bus.error_count !== 16'd1 || bus.expected !== 7'd41) begin
            errors++;
            $display("FAIL single_state got cnt=%0d x=%0d want 1 41",
                     bus.error_count, bus.expected);
        end
        pulses = 0;
        for (int i = 41; i <= 50; i++) begin
            step(1'b1, 7'(i), 1'b0);
            if (bus.error === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.error_count !== 16'd1) begin
            errors++;
            $display("FAIL single_after got pulses=%0d cnt=%0d want 0 1",
                     pulses, bus.error_count);
        end
        checks++;
        if (bus.sample_count !== 16'd46 || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL single_samples got=%0d l=%b want 46 1",
                     bus.sample_count, bus.locked);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        do_reset();
        feed(0, 19);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 7'(40 + k), 1'b0);
            checks++;
            if (bus.error !== 1'b1 || bus.locked !== (k < 2)) begin
                errors++;
                $display("FAIL jump_mis k=%0d got e=%b l=%b want 1 %b",
                         k, bus.error, bus.locked, (k < 2));
            end
        end
        checks++;
        if (bus.error_count !== 16'd3 || bus.expected !== 7'd43) begin
            errors++;
            $display("FAIL jump_drop got cnt=%0d x=%0d want 3 43",
                     bus.error_count, bus.expected);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 7'(43 + k), 1'b0);
            checks++;
            if (bus.locked !== (k == 3) || bus.error !== 1'b0) begin
                errors++;
                $display("FAIL jump_relock k=%0d got l=%b e=%b want %b 0",
                         k, bus.locked, bus.error, (k == 3));
            end
        end
        pulses = 0;
        for (int i = 47; i <= 50; i++) begin
            step(1'b1, 7'(i), 1'b0);
            if (bus.error === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.error_count !== 16'd3 ||
            bus.sample_count !== 16'd22) begin
            errors++;
            $display("FAIL jump_after got p=%0d e=%0d s=%0d want 0 3 22",
                     pulses, bus.error_count, bus.sample_count);
        end
    endtask

    task automatic test_enable_gaps();
        logic [6:0] hold_exp;
        logic [15:0] hold_smp;
        do_reset();
        for (int i = 0; i <= 9; i++) begin
            step(1'b1, 7'(i), 1'b0);
            checks++;
            if (bus.locked !== (i >= 4) || bus.error !== 1'b0) begin
                errors++;
                $display("FAIL gap_lock i=%0d got l=%b e=%b want %b 0",
                         i, bus.locked, bus.error, (i >= 4));
            end
            hold_exp = bus.expected;
            hold_smp = bus.sample_count;
            step(1'b0, 7'(i), 1'b0);
            checks++;
            if (bus.expected !== hold_exp ||
                bus.sample_count !== hold_smp ||
                bus.locked !== (i >= 4)) begin
                errors++;
                $display("FAIL gap_idle i=%0d got x=%0d s=%0d want %0d %0d",
                         i, bus.expected, bus.sample_count,
                         hold_exp, hold_smp);
            end
        end
        checks++;
        if (bus.sample_count !== 16'd5 || bus.error_count !== 16'd0) begin
            errors++;
            $display("FAIL gap_counts got s=%0d e=%0d want 5 0",
                     bus.sample_count, bus.error_count);
        end
    endtask

    task automatic test_clear();
        do_reset();
        feed(0, 9);
        checks++;
        if (bus.sample_count !== 16'd5) begin
            errors++;
            $display("FAIL clear_pre got=%0d want=5", bus.sample_count);
        end
        step(1'b1, 7'h55, 1'b1);
        checks++;
        if (bus.error_count !== 16'd0 || bus.sample_count !== 16'd0 ||
            bus.wrap_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_counts got %0d %0d %0d want 0 0 0",
                     bus.error_count, bus.sample_count, bus.wrap_count);
        end
        checks++;
        if (bus.error !== 1'b1 || bus.locked !== 1'b1 ||
            bus.expected !== 7'd11) begin
            errors++;
            $display("FAIL clear_state got e=%b l=%b x=%0d want 1 1 11",
                     bus.error, bus.locked, bus.expected);
        end
        step(1'b1, 7'd11, 1'b0);
        checks++;
        if (bus.error !== 1'b0 || bus.sample_count !== 16'd1 ||
            bus.error_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_after got e=%b s=%0d c=%0d want 0 1 0",
                     bus.error, bus.sample_count, bus.error_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        feed(0, 9);
        step(1'b1, 7'h33, 1'b0);
        checks++;
        if (bus.error !== 1'b1 || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got e=%b l=%b want 1 1",
                     bus.error, bus.locked);
        end
        @(negedge clock);
        bus.enable = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.locked !== 1'b0 || bus.error !== 1'b0 ||
            bus.expected !== 7'd0) begin
            errors++;
            $display("FAIL mid_async got l=%b e=%b x=%0d want 0 0 0",
                     bus.locked, bus.error, bus.expected);
        end
        checks++;
        if (bus.error_count !== 16'd0 || bus.sample_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_counts got e=%0d s=%0d want 0 0",
                     bus.error_count, bus.sample_count);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 7'(50 + k), 1'b0);
            checks++;
            if (bus.locked !== (k == 4)) begin
                errors++;
                $display("FAIL mid_relock k=%0d got=%b want=%b",
                         k, bus.locked, (k == 4));
            end
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b0;
        bus.enable  = 1'b0;
        bus.data_in = '0;
        bus.clear   = 1'b0;
        test_reset();
        test_clean_ramp();
        test_single_error();
        test_back_to_back();
        test_enable_gaps();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
